// File: rtl/alu_pkg.sv
// Shared state encoding and opcode constants for the ALU, its UART front end and the bench.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_EXEC = 3'd3,
    ST_TX   = 3'd4
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_op_check.sv
// Combinational opcode-legality decoder; only the eight ALU opcodes are legal.
module alu_op_check
  import alu_pkg::*;
#(
  parameter int NB_OP = 6
) (
  input  logic [NB_OP-1:0] op,
  output logic             legal
);

  // Match the incoming opcode against the supported set
  always_comb begin
    legal = 1'b0;
    case (op)
      NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
      NB_OP'(OP_XOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL), NB_OP'(OP_NOR): legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_uart_if.sv
// Byte-serial front end for the ALU: collects A, B and opcode from the UART, runs the ALU and sends the result.
// Define ALU_UART_IF_OP_CHECK_EN to reject unsupported opcodes with a one-cycle o_error pulse.
module alu_uart_if
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_alu_valid,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_error
);

  state_e             state_r, state_next_s;
  logic [NB_DATA-1:0] data_a_r, data_a_next_s;
  logic [NB_DATA-1:0] data_b_r, data_b_next_s;
  logic [NB_OP-1:0]   op_r, op_next_s;
  logic [NB_DATA-1:0] tx_data_r, tx_data_next_s;
  logic               alu_valid_r, alu_valid_next_s;
  logic               tx_start_r, tx_start_next_s;
  logic               op_legal_s;

`ifdef ALU_UART_IF_OP_CHECK_EN
  logic error_r;

  alu_op_check #(
    .NB_OP(NB_OP)
  ) u_op_check (
    .op   (i_rx_data[NB_OP-1:0]),
    .legal(op_legal_s)
  );

  // A rejected opcode byte produces a single-cycle error strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      error_r <= 1'b0;
    end else begin
      error_r <= (state_r == ST_OP) && i_rx_done && !op_legal_s;
    end
  end

  assign o_error = error_r;
`else
  assign op_legal_s = 1'b1;
  assign o_error    = 1'b0;
`endif

  // Next-state and next-output decode; registers hold unless a state acts on them
  always_comb begin
    state_next_s   = state_r;
    data_a_next_s  = data_a_r;
    data_b_next_s  = data_b_r;
    op_next_s      = op_r;
    tx_data_next_s = tx_data_r;
    case (state_r)
      ST_A: begin
        if (i_rx_done) begin
          state_next_s  = ST_B;
          data_a_next_s = i_rx_data;
        end else begin
          state_next_s = ST_A;
        end
      end
      ST_B: begin
        if (i_rx_done) begin
          state_next_s  = ST_OP;
          data_b_next_s = i_rx_data;
        end else begin
          state_next_s = ST_B;
        end
      end
      ST_OP: begin
        if (i_rx_done && op_legal_s) begin
          state_next_s = ST_EXEC;
          op_next_s    = i_rx_data[NB_OP-1:0];
        end else begin
          state_next_s = ST_OP;
        end
      end
      ST_EXEC: begin
        state_next_s   = ST_TX;
        tx_data_next_s = i_alu_result;
      end
      // Received bytes are dropped here, even when they coincide with i_tx_done
      ST_TX: begin
        if (i_tx_done) begin
          state_next_s = ST_A;
        end else begin
          state_next_s = ST_TX;
        end
      end
      default: begin
        state_next_s = ST_A;
      end
    endcase
    alu_valid_next_s = (state_next_s == ST_EXEC);
    tx_start_next_s  = (state_r == ST_EXEC);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= ST_A;
      data_a_r    <= {NB_DATA{1'b0}};
      data_b_r    <= {NB_DATA{1'b0}};
      op_r        <= {NB_OP{1'b0}};
      tx_data_r   <= {NB_DATA{1'b0}};
      alu_valid_r <= 1'b0;
      tx_start_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      data_a_r    <= data_a_next_s;
      data_b_r    <= data_b_next_s;
      op_r        <= op_next_s;
      tx_data_r   <= tx_data_next_s;
      alu_valid_r <= alu_valid_next_s;
      tx_start_r  <= tx_start_next_s;
    end
  end

  assign o_data_a    = data_a_r;
  assign o_data_b    = data_b_r;
  assign o_op        = op_r;
  assign o_tx_data   = tx_data_r;
  assign o_alu_valid = alu_valid_r;
  assign o_tx_start  = tx_start_r;

endmodule
